// File: rtl/skinny_sbox_layer_seq.sv
// Serial SubCells sequencer for a 3-share masked SKINNY-64 round. It feeds one
// nibble per cycle into an external LAT-stage shared S-box and reassembles its outputs.
module skinny_sbox_layer_seq #(
  parameter int CELLS = 16,
  parameter int LAT   = 4
) (
  input  logic                 clk,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [4*CELLS-1:0]   st_in1_i,
  input  logic [4*CELLS-1:0]   st_in2_i,
  input  logic [4*CELLS-1:0]   st_in3_i,
  input  logic [31:0]          rand_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [4*CELLS-1:0]   st_out1_o,
  output logic [4*CELLS-1:0]   st_out2_o,
  output logic [4*CELLS-1:0]   st_out3_o,
  output logic [3:0]           sb_in1_o,
  output logic [3:0]           sb_in2_o,
  output logic [3:0]           sb_in3_o,
  output logic [23:0]          sb_r_o,
  output logic [7:0]           sb_rc_o,
  input  logic [3:0]           sb_out1_i,
  input  logic [3:0]           sb_out2_i,
  input  logic [3:0]           sb_out3_i
);

  localparam int W  = 4 * CELLS;
  localparam int CW = $clog2(CELLS + LAT + 1);
  localparam int IW = $clog2(CELLS);

  localparam logic [CW-1:0] CELLS_C = CW'(CELLS);
  localparam logic [CW-1:0] LAT_C   = CW'(LAT);
  localparam logic [CW-1:0] LAST_C  = CW'(CELLS + LAT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    sh1, sh2, sh3;

  logic            present;
  logic            capture;
  logic [IW-1:0]   in_idx;
  logic [IW-1:0]   cap_idx;
  logic [IW+1:0]   in_off;
  logic [IW+1:0]   cap_off;

  // Nibble cnt goes out in cycle cnt; its S-box result returns LAT cycles later.
  assign present = (state == RUN) && (cnt < CELLS_C);
  assign capture = (state == RUN) && (cnt >= LAT_C);
  assign in_idx  = IW'(cnt);
  assign cap_idx = IW'(cnt - LAT_C);
  assign in_off  = {in_idx, 2'b00};
  assign cap_off = {cap_idx, 2'b00};

  // Each share index has its own datapath; shares never mix here.
  assign sb_in1_o = present ? sh1[in_off +: 4] : 4'h0;
  assign sb_in2_o = present ? sh2[in_off +: 4] : 4'h0;
  assign sb_in3_o = present ? sh3[in_off +: 4] : 4'h0;

  assign sb_r_o  = rand_i[23:0];
  assign sb_rc_o = rand_i[31:24];

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      sh1       <= '0;
      sh2       <= '0;
      sh3       <= '0;
      st_out1_o <= '0;
      st_out2_o <= '0;
      st_out3_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            sh1    <= st_in1_i;
            sh2    <= st_in2_i;
            sh3    <= st_in3_i;
            cnt    <= '0;
            busy_o <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          if (capture) begin
            st_out1_o[cap_off +: 4] <= sb_out1_i;
            st_out2_o[cap_off +: 4] <= sb_out2_i;
            st_out3_o[cap_off +: 4] <= sb_out3_i;
          end
          if (cnt == LAST_C) begin
            busy_o <= 1'b0;
            done_o <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_o <= 1'b0;
          done_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
